// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: the buffered entry layout and the default
// reset PC / sequential step, also used by decode and branch-target logic.
package fetch_pkg;

  localparam int FETCH_ADDR_W  = 32;
  localparam int FETCH_INSTR_W = 32;

  localparam logic [FETCH_ADDR_W-1:0] FETCH_RESET_PC = 32'h0000_0000;
  localparam int                      FETCH_PC_STEP  = 4;

  // One prefetched instruction together with the address it came from.
  typedef struct packed {
    logic [FETCH_ADDR_W-1:0]  pc;
    logic [FETCH_INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular prefetch buffer of fetch_entry_t. Head is read combinationally;
// push, pop and flush take effect on the rising edge. DEPTH must be a power
// of two so the pointers wrap naturally.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  fetch_entry_t     i_entry,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [CNT_W-1:0] o_count,
  output fetch_entry_t     o_head
);

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic             w_push;

  // A flush discards everything, so a push in the same cycle is ignored.
  assign w_push = i_push & ~i_flush;

  // Pointer and occupancy bookkeeping; flush empties the buffer outright.
  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + PTR_W'(1);
      end
      if (i_pop) begin
        r_head <= r_head + PTR_W'(1);
      end
      case ({w_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage carries no reset; occupancy alone says what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_tail] <= i_entry;
    end
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_head];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses the combinational
// instruction memory, buffers {pc, instr} pairs for decode and handles
// branch/jump redirects by reloading the PC and flushing the buffer.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter  int                     INS_ADDRESS = FETCH_ADDR_W,
  parameter  int                     INS_W       = FETCH_INSTR_W,
  parameter  logic [INS_ADDRESS-1:0] RESET_PC    = FETCH_RESET_PC,
  parameter  int                     PC_STEP     = FETCH_PC_STEP,
  parameter  int                     DEPTH       = 2,
  localparam int                     CNT_W       = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic [INS_ADDRESS-1:0] imem_addr,
  input  logic [INS_W-1:0]       imem_instr,
  input  logic                   redirect_valid,
  input  logic [INS_ADDRESS-1:0] redirect_target,
  output logic                   id_valid,
  input  logic                   id_ready,
  output logic [INS_W-1:0]       id_instr,
  output logic [INS_ADDRESS-1:0] id_pc,
  output logic [INS_ADDRESS-1:0] id_pc_next,
  output logic [CNT_W-1:0]       occupancy
);

  localparam logic [INS_ADDRESS-1:0] STEP = INS_ADDRESS'(PC_STEP);

  logic [INS_ADDRESS-1:0] r_pc;
  logic [CNT_W-1:0]       w_count;
  fetch_entry_t           w_head;
  fetch_entry_t           w_entry;
  logic                   w_valid;
  logic                   w_pop;
  logic                   w_can_push;
  logic                   w_push;

  // Handshake: a pop frees a slot in the same cycle, so a full buffer with
  // decode accepting still fetches without a bubble.
  assign w_valid    = (w_count != '0);
  assign w_pop      = w_valid & id_ready;
  assign w_can_push = (w_count < CNT_W'(DEPTH)) | w_pop;
  assign w_push     = ~redirect_valid & w_can_push;

  assign w_entry = '{pc: r_pc, instr: imem_instr};

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_entry (w_entry),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .o_count (w_count),
    .o_head  (w_head)
  );

  // Next-PC select: reset beats redirect beats sequential fetch; a stalled
  // fetch keeps the PC, so the memory address is stable while full.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_pc <= redirect_target;
    end else if (w_can_push) begin
      r_pc <= r_pc + STEP;
    end
  end

  // Decode-facing outputs come only from buffer state; zero when empty.
  assign imem_addr  = r_pc;
  assign id_valid   = w_valid;
  assign id_instr   = w_valid ? w_head.instr       : '0;
  assign id_pc      = w_valid ? w_head.pc          : '0;
  assign id_pc_next = w_valid ? (w_head.pc + STEP) : '0;
  assign occupancy  = w_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random traffic
// against a queue-based reference model, with a scoreboard of consumed entries.
module tb_fetch_unit;

  localparam int DEPTH = 2;

  logic        clk;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_next;
  logic [1:0]  occupancy;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        mq[$];
  ent_t        exp_q[$];
  logic [31:0] mpc;
  bit          minit;
  int          checks;
  int          failures;

  fetch_unit #(
    .INS_ADDRESS (32),
    .INS_W       (32),
    .RESET_PC    (32'h0),
    .PC_STEP     (4),
    .DEPTH       (DEPTH)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_addr       (imem_addr),
    .imem_instr      (imem_instr),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .id_valid        (id_valid),
    .id_ready        (id_ready),
    .id_instr        (id_instr),
    .id_pc           (id_pc),
    .id_pc_next      (id_pc_next),
    .occupancy       (occupancy)
  );

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  assign imem_instr = mem_f(imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // One cycle: drive inputs after the falling edge, compare DUT state with the
  // model, then advance the model by the fetch rules.
  task automatic step(input bit r, input bit rv, input logic [31:0] tgt, input bit rdy);
    bit mvalid;
    bit pop;
    @(negedge clk);
    reset           = r;
    redirect_valid  = rv;
    redirect_target = tgt;
    id_ready        = rdy;
    #1;
    if (minit) begin
      mvalid = (mq.size() != 0);
      chk("imem_addr", imem_addr, mpc);
      chk("occupancy", 32'(occupancy), 32'(mq.size()));
      chk("id_valid", 32'(id_valid), 32'(mvalid));
      if (mvalid) begin
        chk("head_pc", id_pc, mq[0].pc);
        chk("head_instr", id_instr, mq[0].instr);
        chk("head_pc_next", id_pc_next, mq[0].pc + 32'd4);
      end else begin
        chk("idle_pc", id_pc, 32'h0);
      end
      pop = mvalid && rdy && !r;
      if (pop) exp_q.push_back(mq[0]);
      if (r) begin
        mq.delete();
        mpc = 32'h0;
      end else if (rv) begin
        mq.delete();
        mpc = tgt;
      end else begin
        if (pop) void'(mq.pop_front());
        if (mq.size() < DEPTH) begin
          mq.push_back('{pc: mpc, instr: mem_f(mpc)});
          mpc = mpc + 32'd4;
        end
      end
    end else if (r) begin
      mq.delete();
      mpc   = 32'h0;
      minit = 1'b1;
    end
  endtask

  // Scoreboard monitor: every DUT handshake must match the next expected entry.
  always begin
    ent_t e;
    @(negedge clk);
    #2;
    if (reset === 1'b0 && id_valid === 1'b1 && id_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected actual_pc=%h required=none", id_pc);
      end else begin
        e = exp_q.pop_front();
        chk("sb_pc", id_pc, e.pc);
        chk("sb_instr", id_instr, e.instr);
        chk("sb_pc_next", id_pc_next, e.pc + 32'd4);
      end
    end
  end

  initial begin
    logic [31:0] tgt;
    checks          = 0;
    failures        = 0;
    minit           = 1'b0;
    reset           = 1'b1;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    id_ready        = 1'b0;

    // Reset then stream
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    repeat (5) step(0, 0, 0, 1);

    // Backpressure from reset, then release
    step(1, 0, 0, 0);
    repeat (5) step(0, 0, 0, 0);
    repeat (5) step(0, 0, 0, 1);

    // Redirect with pop: fill 24,28 then redirect to 30 while popping
    step(0, 1, 32'd24, 0);
    repeat (3) step(0, 0, 0, 0);
    step(0, 1, 32'd30, 1);
    repeat (5) step(0, 0, 0, 1);

    // Redirect while full and stalled
    repeat (3) step(0, 0, 0, 0);
    step(0, 1, 32'd58, 0);
    repeat (3) step(0, 0, 0, 0);
    repeat (3) step(0, 0, 0, 1);

    // PC wrap
    step(0, 1, 32'hFFFF_FFFC, 1);
    repeat (5) step(0, 0, 0, 1);

    // Reset priority over redirect and pop
    step(0, 0, 0, 1);
    step(1, 1, 32'h0000_1234, 1);
    repeat (3) step(0, 0, 0, 1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0)
        tgt = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4);
      else
        tgt = $urandom;
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) == 0), tgt,
           ($urandom_range(0, 9) < 7));
    end

    step(0, 0, 0, 0);
    #5;
    chk("sb_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
